cluster_level_shifter_in_rx: RTL and testbench

// Receive side of the SoC->cluster crossing: captures a 4-phase req/ack word

---
 rtl/cluster_level_shifter_in_rx.sv | 77 +++++++
 tb/tb_cluster_level_shifter_in_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_level_shifter_in_rx.sv
// Receive side of the SoC->cluster crossing: synchronizes a 4-phase req/ack
// word from the input level shifters and presents it as a valid/ready stream.
module cluster_level_shifter_in_rx #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iso_i,
  input  logic                  ls_req_i,
  input  logic [DATA_WIDTH-1:0] ls_data_i,
  output logic                  ls_ack_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    ACK
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_q;
  logic                    req_g;
  logic                    req_s;
  logic [DATA_WIDTH-1:0]   data_g;

  // Clamp while the SoC-side supply may be off; a clamped req drains the chain.
  assign req_g    = ls_req_i & ~iso_i;
  assign data_g   = iso_i ? '0 : ls_data_i;
  assign req_s    = sync_q[SYNC_STAGES-1];
  assign ls_ack_o = ack_q & ~iso_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_g};
      case (state_q)
        IDLE: begin
          if (req_s) begin
            data_o  <= data_g;
            valid_o <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          // Waiting for req_s low keeps a held req from producing a second word.
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_level_shifter_in_rx.sv
// Directed and randomized checks of the SoC->cluster receive crossing.
module tb_cluster_level_shifter_in_rx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iso_i;
  logic        ls_req_i;
  logic [31:0] ls_data_i;
  logic        ls_ack_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  cluster_level_shifter_in_rx #(
    .DATA_WIDTH (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .iso_i    (iso_i),
    .ls_req_i (ls_req_i),
    .ls_data_i(ls_data_i),
    .ls_ack_o (ls_ack_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] w;
  logic [31:0] exp_w;
  logic [31:0] prev_data;
  logic        prev_valid;
  logic        prev_ready;
  int          sent;
  int          got;
  int          sst;
  int          gap;
  int          iso_left;

  initial begin
    // Reset with req already high
    rst_i     = 1'b1;
    iso_i     = 1'b0;
    ready_i   = 1'b0;
    ls_req_i  = 1'b1;
    ls_data_i = 32'hA5A5A5A5;
    tick(2);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ack", {31'd0, ls_ack_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    rst_i = 1'b0;
    tick(2);
    check("rel_valid_early", {31'd0, valid_o}, 32'd0);
    tick(1);
    check("rel_valid", {31'd0, valid_o}, 32'd1);
    check("rel_data", data_o, 32'hA5A5A5A5);
    ready_i = 1'b1;
    tick(1);
    check("rel_ack", {31'd0, ls_ack_o}, 32'd1);
    ls_req_i = 1'b0;
    tick(3);
    check("rel_ack_fall", {31'd0, ls_ack_o}, 32'd0);

    // Single transfer with ready high
    ls_data_i = 32'hDEADBEEF;
    ls_req_i  = 1'b1;
    tick(2);
    check("single_valid_e2", {31'd0, valid_o}, 32'd0);
    tick(1);
    check("single_valid_e3", {31'd0, valid_o}, 32'd1);
    check("single_data", data_o, 32'hDEADBEEF);
    check("single_ack_e3", {31'd0, ls_ack_o}, 32'd0);
    tick(1);
    check("single_ack_e4", {31'd0, ls_ack_o}, 32'd1);
    check("single_valid_e4", {31'd0, valid_o}, 32'd0);
    ls_req_i = 1'b0;
    tick(2);
    check("single_ack_hold", {31'd0, ls_ack_o}, 32'd1);
    tick(1);
    check("single_ack_fall", {31'd0, ls_ack_o}, 32'd0);

    // Back-pressure
    ready_i   = 1'b0;
    ls_data_i = 32'hCAFEF00D;
    ls_req_i  = 1'b1;
    tick(3);
    check("bp_valid", {31'd0, valid_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_hold_valid", {31'd0, valid_o}, 32'd1);
      check("bp_hold_data", data_o, 32'hCAFEF00D);
      check("bp_hold_ack", {31'd0, ls_ack_o}, 32'd0);
    end
    ready_i = 1'b1;
    tick(1);
    check("bp_ack", {31'd0, ls_ack_o}, 32'd1);

    // Held req after ack: no second word
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("held_ack", {31'd0, ls_ack_o}, 32'd1);
      check("held_no_word", {31'd0, valid_o}, 32'd0);
    end
    ls_req_i = 1'b0;
    ready_i  = 1'b0;
    tick(3);
    check("held_ack_fall", {31'd0, ls_ack_o}, 32'd0);

    // Isolation while a word is pending
    ls_data_i = 32'h12345678;
    ls_req_i  = 1'b1;
    tick(3);
    check("iso_pending", {31'd0, valid_o}, 32'd1);
    iso_i = 1'b1;
    tick(1);
    check("iso_hold_valid", {31'd0, valid_o}, 32'd1);
    check("iso_hold_data", data_o, 32'h12345678);
    check("iso_hold_ack", {31'd0, ls_ack_o}, 32'd0);
    ready_i = 1'b1;
    tick(1);
    check("iso_deliver", {31'd0, valid_o}, 32'd0);
    check("iso_ack_masked", {31'd0, ls_ack_o}, 32'd0);
    ready_i = 1'b0;
    tick(4);
    check("iso_idle_ack", {31'd0, ls_ack_o}, 32'd0);
    check("iso_idle_valid", {31'd0, valid_o}, 32'd0);
    iso_i = 1'b0;
    tick(2);
    check("iso_rel_early", {31'd0, valid_o}, 32'd0);
    check("iso_rel_ack", {31'd0, ls_ack_o}, 32'd0);
    tick(1);
    check("iso_recapture", {31'd0, valid_o}, 32'd1);
    check("iso_recapture_data", data_o, 32'h12345678);
    ready_i = 1'b1;
    tick(1);
    check("iso_re_ack", {31'd0, ls_ack_o}, 32'd1);
    ls_req_i = 1'b0;
    ready_i  = 1'b0;
    tick(3);
    check("iso_re_ack_fall", {31'd0, ls_ack_o}, 32'd0);

    // Randomized 4-phase sender against an in-order scoreboard
    sent       = 0;
    got        = 0;
    sst        = 0;
    gap        = 0;
    iso_left   = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 20000 && got < 100; cyc++) begin
      if (prev_valid && !prev_ready) begin
        check("rnd_hold_valid", {31'd0, valid_o}, 32'd1);
        check("rnd_hold_data", data_o, prev_data);
      end
      if (iso_i) begin
        check("rnd_iso_ack", {31'd0, ls_ack_o}, 32'd0);
        check("rnd_iso_valid", {31'd0, valid_o}, 32'd0);
      end

      if (iso_left > 0) begin
        iso_left--;
        if (iso_left == 0) iso_i = 1'b0;
      end else if (sst == 0 && !valid_o && $urandom_range(0, 7) == 0) begin
        iso_i    = 1'b1;
        iso_left = $urandom_range(1, 4);
      end

      case (sst)
        0: begin
          if (gap > 0) gap--;
          else if (iso_left == 0 && sent < 100) begin
            w         = $urandom;
            ls_data_i = w;
            ls_req_i  = 1'b1;
            q.push_back(w);
            sent++;
            sst = 1;
          end
        end
        1: if (ls_ack_o) begin
          ls_req_i = 1'b0;
          sst      = 2;
        end
        default: if (!ls_ack_o) begin
          sst = 0;
          gap = $urandom_range(0, 3);
        end
      endcase

      ready_i = ($urandom_range(0, 3) != 0);
      if (valid_o && ready_i) begin
        exp_w = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
        check("rnd_word", data_o, exp_w);
        got++;
      end
      prev_valid = valid_o;
      prev_ready = ready_i;
      prev_data  = data_o;
      tick(1);
    end
    check("rnd_delivered", got, 32'd100);
    check("rnd_leftover", q.size(), 32'd0);

    ls_req_i = 1'b0;
    ready_i  = 1'b0;
    iso_i    = 1'b0;
    tick(10);
    check("rnd_no_extra", {31'd0, valid_o}, 32'd0);
    check("rnd_ack_idle", {31'd0, ls_ack_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
